// File: rtl/tdm_mux41.sv
// Four-channel TDM multiplexer: captures a frame of four words and sends them one slot per
// accepted cycle with ready/valid pacing. Optional parity output enabled by TDM_MUX_PARITY_EN.
module tdm_mux41 #(
    parameter int unsigned W = 1
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [W-1:0] iD0,
    input  logic [W-1:0] iD1,
    input  logic [W-1:0] iD2,
    input  logic [W-1:0] iD3,
    input  logic         iLoad,
    input  logic         iReady,
    output logic [W-1:0] oZ,
    output logic         oS1,
    output logic         oS0,
    output logic         oValid,
    output logic         oFrame,
    output logic         oBusy,
    output logic         oDone
`ifdef TDM_MUX_PARITY_EN
    ,
    output logic         oPar
`endif
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e         stateQ, stateD;
    logic   [1:0]   slotQ, slotD;
    logic   [W-1:0] bufQ [4];
    logic   [W-1:0] bufD [4];
    logic   [W-1:0] zQ, zD;
    logic           frameQ, frameD;
    logic           doneQ, doneD;
    logic           accept, lastAccept, capture;

    always_comb begin
        stateD     = stateQ;
        slotD      = slotQ;
        bufD       = bufQ;
        zD         = zQ;
        frameD     = frameQ;
        accept     = (stateQ == StSend) && iReady;
        lastAccept = accept && (slotQ == 2'd3);
        capture    = (stateQ == StIdle) || lastAccept;
        doneD      = lastAccept;

        if (capture && iLoad) begin
            // New frame goes straight out as slot 0, so back-to-back frames have no bubble.
            bufD[0] = iD0;
            bufD[1] = iD1;
            bufD[2] = iD2;
            bufD[3] = iD3;
            stateD  = StSend;
            slotD   = 2'd0;
            zD      = iD0;
            frameD  = 1'b1;
        end else if (lastAccept) begin
            stateD = StIdle;
            slotD  = 2'd0;
            zD     = '0;
            frameD = 1'b0;
        end else if (accept) begin
            slotD  = slotQ + 2'd1;
            zD     = bufQ[slotQ + 2'd1];
            frameD = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ <= StIdle;
            slotQ  <= 2'd0;
            zQ     <= '0;
            frameQ <= 1'b0;
            doneQ  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                bufQ[i] <= '0;
            end
        end else begin
            stateQ <= stateD;
            slotQ  <= slotD;
            zQ     <= zD;
            frameQ <= frameD;
            doneQ  <= doneD;
            bufQ   <= bufD;
        end
    end

`ifdef TDM_MUX_PARITY_EN
    logic parQ;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            parQ <= 1'b0;
        end else begin
            parQ <= ^zD;
        end
    end

    assign oPar = parQ;
`endif

    assign oZ     = zQ;
    assign oS1    = slotQ[1];
    assign oS0    = slotQ[0];
    assign oValid = (stateQ == StSend);
    assign oBusy  = (stateQ == StSend);
    assign oFrame = frameQ;
    assign oDone  = doneQ;

endmodule

// File: tb/tb_tdm_mux41.sv
// Randomized and directed bench for tdm_mux41 (W = 4) against a slot-queue reference model.
module tb_tdm_mux41;

    logic       iClk = 1'b0;
    logic       iRst, iLoad, iReady;
    logic [3:0] iD0, iD1, iD2, iD3;
    logic [3:0] oZ;
    logic       oS1, oS0, oValid, oFrame, oBusy, oDone, oPar;

    int nChecks = 0;
    int nFails  = 0;
    int cycle   = 0;

    // Reference model: the frame is a queue of pending slots (word, index); front is presented.
    int  wordQ[$];
    int  idxQ[$];
    bit  mDone = 1'b0;
    logic [3:0] dIn [4];

    tdm_mux41 #(.W(4)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iD0    (iD0),
        .iD1    (iD1),
        .iD2    (iD2),
        .iD3    (iD3),
        .iLoad  (iLoad),
        .iReady (iReady),
        .oZ     (oZ),
        .oS1    (oS1),
        .oS0    (oS0),
        .oValid (oValid),
        .oFrame (oFrame),
        .oBusy  (oBusy),
        .oDone  (oDone)
`ifdef TDM_MUX_PARITY_EN
        ,
        .oPar   (oPar)
`endif
    );

`ifndef TDM_MUX_PARITY_EN
    assign oPar = 1'b0;
`endif

    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, want);
        end
    endtask

    task automatic checkAll();
        logic [3:0] expZ;
        int         expIdx;
        bit         v;
        v      = wordQ.size() > 0;
        expZ   = v ? 4'(wordQ[0]) : 4'd0;
        expIdx = v ? idxQ[0] : 0;
        checkVal("valid", 32'(oValid), 32'(v));
        checkVal("busy", 32'(oBusy), 32'(v));
        checkVal("z", 32'(oZ), 32'(expZ));
        checkVal("sel", 32'({oS1, oS0}), 32'(expIdx));
        checkVal("frame", 32'(oFrame), 32'(v && expIdx == 0));
        checkVal("done", 32'(oDone), 32'(mDone));
`ifdef TDM_MUX_PARITY_EN
        checkVal("par", 32'(oPar), 32'(^expZ));
`endif
    endtask

    task automatic step(input bit rst, input bit load, input bit ready);
        bit acc, last;
        iRst   = rst;
        iLoad  = load;
        iReady = ready;
        iD0 = dIn[0];
        iD1 = dIn[1];
        iD2 = dIn[2];
        iD3 = dIn[3];
        @(posedge iClk);
        cycle++;
        acc = (wordQ.size() > 0) && ready;
        if (rst) begin
            wordQ.delete();
            idxQ.delete();
            mDone = 1'b0;
        end else begin
            last = 1'b0;
            if (acc) last = (idxQ[0] == 3);
            mDone = last;
            if (acc) begin
                void'(wordQ.pop_front());
                void'(idxQ.pop_front());
            end
            if ((wordQ.size() == 0) && load) begin
                for (int k = 0; k < 4; k++) begin
                    wordQ.push_back(int'(dIn[k]));
                    idxQ.push_back(k);
                end
            end
        end
        #1;
        checkAll();
    endtask

    task automatic setData(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d);
        dIn[0] = a;
        dIn[1] = b;
        dIn[2] = c;
        dIn[3] = d;
    endtask

    initial begin
        setData(4'h0, 4'h0, 4'h0, 4'h0);
        iRst = 1'b1; iLoad = 1'b1; iReady = 1'b1;
        iD0 = '0; iD1 = '0; iD2 = '0; iD3 = '0;

        // Reset held with iLoad high.
        setData(4'h7, 4'h7, 4'h7, 4'h7);
        step(1, 1, 1);
        step(1, 1, 1);
        checkVal("rst_valid", 32'(oValid), 32'd0);
        step(0, 0, 1);

        // Single frame.
        setData(4'h3, 4'h5, 4'hA, 4'hF);
        step(0, 1, 1);
        checkVal("single_s0", 32'(oZ), 32'h3);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        checkVal("single_s3", 32'({oZ, oS1, oS0}), 32'({4'hF, 2'b11}));
        step(0, 0, 1);
        checkVal("single_done", 32'(oDone), 32'd1);
        step(0, 0, 1);

        // Stall on slot 1 while data changes.
        step(0, 1, 1);
        step(0, 0, 1);
        setData(4'h9, 4'h9, 4'h9, 4'h9);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            checkVal("stall_hold", 32'({oZ, oS1, oS0}), 32'({4'h5, 2'b01}));
        end
        step(0, 0, 1);
        checkVal("stall_resume", 32'(oZ), 32'hA);
        step(0, 0, 1);
        step(0, 0, 1);

        // Back-to-back frames.
        setData(4'h1, 4'h2, 4'h3, 4'h4);
        step(0, 1, 1);
        setData(4'h8, 4'h9, 4'hA, 4'hB);
        for (int i = 0; i < 7; i++) step(0, 1, 1);
        checkVal("b2b_last", 32'(oZ), 32'hB);
        step(0, 0, 1);

        // Mid-frame reset during slot 2.
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        checkVal("mid_slot2", 32'({oS1, oS0}), 32'd2);
        step(1, 0, 1);
        step(0, 0, 1);
        checkVal("mid_nodone", 32'(oDone), 32'd0);
        step(0, 1, 1);

        // Parity pattern with a stall.
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        setData(4'h0, 4'h1, 4'h3, 4'h7);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);

        // Randomized traffic, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            setData(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/tdm_mux41.md
# tdm_mux41

Four-channel time-division multiplexer and transmit-side counterpart of the 1-to-4 data distributor. It captures a frame of four channel words, then drives them onto a single data line one slot per accepted cycle. Each slot carries the select code (oS1, oS0) that the distributor uses to route the word back to output 0–3. A ready/valid handshake paces the transfer, and back-to-back frames are supported with no idle cycle.

## Interface
- W, default 1, width of each channel word and of oZ (W ≥ 1).
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous reset, active-high.
- iD0  input  W  channel 0 word, sampled only at frame capture.
- iD1  input  W  channel 1 word, sampled only at frame capture.
- iD2  input  W  channel 2 word, sampled only at frame capture.
- iD3  input  W  channel 3 word, sampled only at frame capture.
- iLoad  input  1  frame request; honoured only at a capture point.
- iReady  input  1  downstream accepts the current slot this cycle.
- oZ  output  W  current slot word (registered).
- oS1  output  1  current slot index, MSB (registered).
- oS0  output  1  current slot index, LSB (registered).
- oValid  output  1  oZ/oS1/oS0 hold a valid slot.
- oFrame  output  1  high while slot 0 is presented.
- oBusy  output  1  frame in progress (equals oValid).
- oDone  output  1  one-cycle pulse after slot 3 is accepted.

## Operation
- Two states:
  - IDLE: oValid = 0.
  - SEND: oValid = 1, 2-bit slot counter s.
- Capture point: in IDLE, or in SEND when slot 3 is accepted (oValid & iReady & s = 3).
- At a capture point with iLoad = 1:
  - iD0–iD3 are latched into a 4×W frame buffer.
  - s is set to 0 and the state becomes SEND.
- Transfer: the slot is accepted when oValid & iReady.
  - If s < 3, s increments.
  - If s = 3 and iLoad = 0, the state returns to IDLE.
  - If s = 3 and iLoad = 1, a new frame is captured and s = 0.
- Presentation in SEND:
  - oZ = buffer[s] and {oS1, oS0} = s.
  - oFrame = (s == 0).
- Stall: while oValid & !iReady, oZ, oS1, oS0, oFrame and s hold unchanged, and iD* and iLoad are ignored.
- iLoad outside a capture point is ignored. It is not queued.
- oDone is registered: high the cycle after slot 3 is accepted, otherwise 0.
- In IDLE, oZ = 0 and {oS1, oS0} = 00.
- Reset values: oZ = 0, oS1 = 0, oS0 = 0, oValid = 0, oFrame = 0, oBusy = 0, oDone = 0. The state is IDLE and the buffer is cleared.
- iRst has priority over every other input. Reset mid-frame discards the frame and does not pulse oDone.

## Timing
- Capture latency: iLoad = 1 at edge N (in IDLE) → slot 0 valid from cycle N+1.
- With iReady held high, a frame takes exactly 4 cycles: slots 0, 1, 2, 3 on consecutive cycles.
- Back-to-back: slot 3 of frame k is followed directly by slot 0 of frame k+1, with no bubble.
- Throughput: 1 slot per cycle, 4 cycles per frame.
- oDone rises in the cycle after the slot 3 acceptance edge and lasts 1 cycle. It can coincide with slot 0 of the next frame.
- iReady has no combinational path to any output. All outputs come directly from flip-flops.

## Configuration
- TDM_MUX_PARITY_EN defined:
  - Adds output oPar (1 bit), registered alongside oZ, equal to the even parity of the presented word (^oZ).
  - oPar is 0 in IDLE and at reset.
  - oPar holds during stalls.
- TDM_MUX_PARITY_EN undefined: the oPar port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert iRst for 2 cycles with iLoad = 1 → every output 0. Release iRst → first slot appears 1 cycle after the next iLoad edge.
- Single frame, W = 4: iD0..iD3 = 3, 5, A, F, iLoad pulsed, iReady = 1.
  - Slots on 4 consecutive cycles: oZ = 3/5/A/F with {oS1, oS0} = 00/01/10/11.
  - oFrame high only with 3.
  - oDone pulses once, then oValid = 0.
- Stall: drop iReady for 3 cycles while slot 1 is presented, and change iD* during the stall → oZ = 5 and {oS1, oS0} = 01 hold unchanged; the sequence resumes at slot 2 with the originally captured data.
- Back-to-back: hold iLoad = 1, with frame 1 = 1, 2, 3, 4 and frame 2 = 8, 9, A, B → 8 consecutive valid slots with no bubble. oDone coincides with slot 0 of frame 2.
- Mid-frame reset: assert iRst during slot 2 → all outputs 0 on the next cycle, no oDone pulse. A new iLoad restarts at slot 0.
- With TDM_MUX_PARITY_EN defined: iD0..iD3 = 0, 1, 3, 7 → oPar = 0, 1, 0, 1, and oPar holds its value through a stall.
